// File: rtl/mat_mult_seq_ctrl.sv
// Sequencer for the 3x3 matrix multiplier (mat_mult).
// - Collects A then B (row-major) from a valid/ready input stream.
// - Packs them onto the 144-bit A/B buses and pulses mult_en once.
// - Captures the C bus and returns it row-major on a valid/ready output stream.
// Bus packing: element k sits at [BUS_W-1-ELEM_W*k -: ELEM_W].
// Optional feature macro: MAT_CTRL_OPCNT_EN adds a 16-bit wrapping op_count output.
module mat_mult_seq_ctrl #(
    parameter int ELEM_W  = 16,
    parameter int MAT_DIM = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [ELEM_W-1:0]                 in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [ELEM_W-1:0]                 out_data,
    output logic                              out_last,
    output logic                              busy,
    output logic [ELEM_W*MAT_DIM*MAT_DIM-1:0] matrix_a_stream,
    output logic [ELEM_W*MAT_DIM*MAT_DIM-1:0] matrix_b_stream,
    output logic                              mult_en,
    input  logic [ELEM_W*MAT_DIM*MAT_DIM-1:0] matrix_c_stream
`ifdef MAT_CTRL_OPCNT_EN
    ,
    output logic [15:0]                       op_count
`endif
);

    localparam int MAT_ELEMS = MAT_DIM * MAT_DIM;
    localparam int IDX_W     = $clog2(MAT_ELEMS);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAT_ELEMS - 1);

    typedef enum logic [2:0] {
        ST_LOAD_A = 3'd0,
        ST_LOAD_B = 3'd1,
        ST_SETTLE = 3'd2,
        ST_MULT   = 3'd3,
        ST_CAPT   = 3'd4,
        ST_DRAIN  = 3'd5
    } state_t;

    state_t                                state_r;
    state_t                                state_nxt_s;
    logic [IDX_W-1:0]                      idx_r;
    logic [IDX_W-1:0]                      idx_nxt_s;
    logic [IDX_W-1:0]                      slot_s;
    logic [MAT_ELEMS-1:0][ELEM_W-1:0]      a_r;
    logic [MAT_ELEMS-1:0][ELEM_W-1:0]      b_r;
    logic [MAT_ELEMS-1:0][ELEM_W-1:0]      c_r;
    logic                                  load_phase_s;
    logic                                  in_fire_s;
    logic                                  out_fire_s;
    logic                                  a_we_s;
    logic                                  b_we_s;
    logic                                  capt_s;

    // Element 0 is the most significant slot, so the packed slot index runs backwards.
    assign slot_s       = LAST_IDX - idx_r;
    assign load_phase_s = (state_r == ST_LOAD_A) || (state_r == ST_LOAD_B);
    // rst gating keeps in_ready low for the whole reset window, not just after it.
    assign in_ready     = rst && load_phase_s;
    assign in_fire_s    = in_valid && load_phase_s;
    assign out_valid    = (state_r == ST_DRAIN);
    assign out_fire_s   = out_valid && out_ready;
    assign out_last     = out_valid && (idx_r == LAST_IDX);
    assign out_data     = out_valid ? c_r[slot_s] : {ELEM_W{1'b0}};
    assign mult_en      = (state_r == ST_MULT);
    assign busy         = (state_r != ST_LOAD_A) || (idx_r != IDX_ZERO);
    assign matrix_a_stream = a_r;
    assign matrix_b_stream = b_r;

    // Next-state, element index and write-strobe decode.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        a_we_s      = 1'b0;
        b_we_s      = 1'b0;
        capt_s      = 1'b0;
        case (state_r)
            ST_LOAD_A: begin
                if (in_fire_s) begin
                    a_we_s = 1'b1;
                    if (idx_r == LAST_IDX) begin
                        state_nxt_s = ST_LOAD_B;
                        idx_nxt_s   = IDX_ZERO;
                    end else begin
                        idx_nxt_s   = idx_r + IDX_ONE;
                    end
                end else begin
                    idx_nxt_s = idx_r;
                end
            end
            ST_LOAD_B: begin
                if (in_fire_s) begin
                    b_we_s = 1'b1;
                    if (idx_r == LAST_IDX) begin
                        state_nxt_s = ST_SETTLE;
                        idx_nxt_s   = IDX_ZERO;
                    end else begin
                        idx_nxt_s   = idx_r + IDX_ONE;
                    end
                end else begin
                    idx_nxt_s = idx_r;
                end
            end
            ST_SETTLE: state_nxt_s = ST_MULT;
            ST_MULT:   state_nxt_s = ST_CAPT;
            ST_CAPT: begin
                capt_s      = 1'b1;
                state_nxt_s = ST_DRAIN;
                idx_nxt_s   = IDX_ZERO;
            end
            ST_DRAIN: begin
                if (out_fire_s) begin
                    if (idx_r == LAST_IDX) begin
                        state_nxt_s = ST_LOAD_A;
                        idx_nxt_s   = IDX_ZERO;
                    end else begin
                        idx_nxt_s   = idx_r + IDX_ONE;
                    end
                end else begin
                    idx_nxt_s = idx_r;
                end
            end
            default: begin
                state_nxt_s = ST_LOAD_A;
                idx_nxt_s   = IDX_ZERO;
            end
        endcase
    end

    // State and element index registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_LOAD_A;
            idx_r   <= IDX_ZERO;
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    // A/B operand buses hold until the next load overwrites them; C is latched in CAPT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_r <= {(ELEM_W*MAT_ELEMS){1'b0}};
            b_r <= {(ELEM_W*MAT_ELEMS){1'b0}};
            c_r <= {(ELEM_W*MAT_ELEMS){1'b0}};
        end else begin
            if (a_we_s) begin
                a_r[slot_s] <= in_data;
            end
            if (b_we_s) begin
                b_r[slot_s] <= in_data;
            end
            if (capt_s) begin
                c_r <= matrix_c_stream;
            end
        end
    end

`ifdef MAT_CTRL_OPCNT_EN
    logic [15:0] op_count_r;
    logic        op_done_s;

    assign op_done_s = out_fire_s && (idx_r == LAST_IDX);
    assign op_count  = op_count_r;

    // Completed-operation counter, bumped on the final output beat, wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_count_r <= 16'h0000;
        end else if (op_done_s) begin
            op_count_r <= op_count_r + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_mat_mult_seq_ctrl.sv
// Directed testbench for mat_mult_seq_ctrl; a behavioural mat_mult stand-in
// answers each mult_en pulse. Define MAT_CTRL_OPCNT_EN to exercise op_count.
module tb_mat_mult_seq_ctrl;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  in_data;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  out_data;
    logic         out_last;
    logic         busy;
    logic [143:0] matrix_a_stream;
    logic [143:0] matrix_b_stream;
    logic         mult_en;
    logic [143:0] matrix_c_stream;
`ifdef MAT_CTRL_OPCNT_EN
    logic [15:0]  op_count;
`endif

    int errors = 0;
    int checks = 0;
    int mult_cnt = 0;
    int early_valid = 0;
    logic loading = 1'b0;

    mat_mult_seq_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .out_last        (out_last),
        .busy            (busy),
        .matrix_a_stream (matrix_a_stream),
        .matrix_b_stream (matrix_b_stream),
        .mult_en         (mult_en),
        .matrix_c_stream (matrix_c_stream)
`ifdef MAT_CTRL_OPCNT_EN
        ,
        .op_count        (op_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] el(input logic [143:0] v, input int k);
        return v[143-16*k -: 16];
    endfunction

    // Multiplier stand-in: unsigned products, truncated to 16 bits.
    function automatic logic [143:0] mm(input logic [143:0] a, input logic [143:0] b);
        logic [143:0] r;
        logic [15:0]  acc;
        logic [31:0]  p;
        r = 144'd0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                acc = 16'd0;
                for (int k = 0; k < 3; k++) begin
                    p   = el(a, i*3+k) * el(b, k*3+j);
                    acc = acc + p[15:0];
                end
                r[143-16*(i*3+j) -: 16] = acc;
            end
        end
        return r;
    endfunction

    initial matrix_c_stream = 144'd0;

    // Multiplier responds one edge after mult_en.
    always @(posedge clk) begin
        if (mult_en) matrix_c_stream <= mm(matrix_a_stream, matrix_b_stream);
    end

    // Pulse counter and early-output monitor.
    always @(negedge clk) begin
        if (mult_en) mult_cnt++;
        if (loading && out_valid) early_valid++;
    end

    task automatic send(input logic [15:0] d, input int gap);
        int t;
        for (int g = 0; g < gap; g++) @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        t = 0;
        while (in_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input logic [143:0] exp, input int nb, input int stall, input string nm);
        logic [15:0] held;
        int t;
        for (int k = 0; k < nb; k++) begin
            t = 0;
            while (out_valid !== 1'b1 && t < 50) begin
                @(negedge clk);
                t++;
            end
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s_valid_timeout beat %0d: out_valid=%b required 1", nm, k, out_valid);
            end
            held = out_data;
            if (stall > 0) begin
                for (int s = 0; s < stall; s++) @(negedge clk);
                checks++;
                if (out_data !== held || out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_stall_hold beat %0d: data=%h valid=%b required %h 1", nm, k, out_data, out_valid, held);
                end
            end
            checks++;
            if (out_data !== el(exp, k) || out_last !== (k == 8)) begin
                errors++;
                $display("FAIL %s_beat %0d: data=%h last=%b required %h %b", nm, k, out_data, out_last, el(exp, k), (k == 8));
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic run_op(input logic [143:0] a, input logic [143:0] b, input logic [143:0] exp,
                          input int gap_max, input int stall, input string nm);
        int lat;
        mult_cnt = 0;
        early_valid = 0;
        loading = 1'b1;
        for (int k = 0; k < 9; k++) begin
            send(el(a, k), (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
            if (k == 0) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_busy: busy=%b required 1", nm, busy);
                end
            end
        end
        for (int k = 0; k < 9; k++) send(el(b, k), (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
        loading = 1'b0;
        checks++;
        if (matrix_a_stream !== a || matrix_b_stream !== b) begin
            errors++;
            $display("FAIL %s_packing: a=%h b=%h required %h %h", nm, matrix_a_stream, matrix_b_stream, a, b);
        end
        checks++;
        if (early_valid != 0) begin
            errors++;
            $display("FAIL %s_early_valid: seen=%0d required 0", nm, early_valid);
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat < 3) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_in_ready_busy: in_ready=%b required 0", nm, in_ready);
                end
            end
        end
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL %s_latency: cycles=%0d required 3", nm, lat);
        end
        drain(exp, 9, stall, nm);
        checks++;
        if (mult_cnt != 1) begin
            errors++;
            $display("FAIL %s_mult_pulses: count=%0d required 1", nm, mult_cnt);
        end
        checks++;
        if (matrix_a_stream !== a || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_post_op: a=%h busy=%b in_ready=%b required %h 0 1", nm, matrix_a_stream, busy, in_ready, a);
        end
    endtask

    localparam logic [143:0] M_ID  = {16'd1, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd1};
    localparam logic [143:0] M_UP  = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
    localparam logic [143:0] M_DN  = {16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
    localparam logic [143:0] M_P2  = {16'd30, 16'd24, 16'd18, 16'd84, 16'd69, 16'd54, 16'd138, 16'd114, 16'd90};
    localparam logic [143:0] M_100 = {9{16'h0100}};
    localparam logic [143:0] M_2   = {9{16'h0002}};
    localparam logic [143:0] M_C   = {9{16'h000C}};

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 16'd0;
        out_ready = 1'b0;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'd0 || out_last !== 1'b0 ||
            mult_en !== 1'b0 || busy !== 1'b0 || matrix_a_stream !== 144'd0 || matrix_b_stream !== 144'd0) begin
            errors++;
            $display("FAIL reset_values: rdy=%b ov=%b od=%h ol=%b me=%b busy=%b", in_ready, out_valid, out_data, out_last, mult_en, busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b busy=%b required 1 0", in_ready, busy);
        end
        @(negedge clk);
    endtask

    task automatic test_identity();
        run_op(M_ID, M_UP, M_UP, 0, 0, "identity");
    endtask

    task automatic test_product();
        run_op(M_UP, M_DN, M_P2, 0, 0, "product");
    endtask

    task automatic test_truncation();
        run_op(M_100, M_100, 144'd0, 0, 0, "trunc_wrap");
        run_op(M_2, M_2, M_C, 0, 1, "trunc_twos");
    endtask

    task automatic test_stalls();
        run_op(M_UP, M_DN, M_P2, 3, 3, "stalls");
    endtask

    task automatic test_reset_abort();
        for (int k = 0; k < 9; k++) send(el(M_UP, k), 0);
        for (int k = 0; k < 5; k++) send(el(M_DN, k), 0);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || matrix_a_stream !== 144'd0 || matrix_b_stream !== 144'd0) begin
            errors++;
            $display("FAIL abort_load: in_ready=%b busy=%b a=%h", in_ready, busy, matrix_a_stream);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_op(M_ID, M_UP, M_UP, 0, 0, "after_abort");
        // Abort in the middle of the drain, on beat 4.
        for (int k = 0; k < 9; k++) send(el(M_UP, k), 0);
        for (int k = 0; k < 9; k++) send(el(M_DN, k), 0);
        drain(M_P2, 3, 0, "abort_drain");
        checks++;
        if (out_valid !== 1'b1 || out_data !== el(M_P2, 3)) begin
            errors++;
            $display("FAIL abort_beat4_pre: valid=%b data=%h required 1 %h", out_valid, out_data, el(M_P2, 3));
        end
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'd0 || out_last !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_drain_reset: valid=%b data=%h last=%b in_ready=%b required 0", out_valid, out_data, out_last, in_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_drain_release: valid=%b in_ready=%b busy=%b required 0 1 0", out_valid, in_ready, busy);
        end
    endtask

`ifdef MAT_CTRL_OPCNT_EN
    task automatic test_opcount();
        logic [15:0] exp_cnt;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checks++;
        if (op_count !== 16'd0) begin
            errors++;
            $display("FAIL opcnt_reset: op_count=%h required 0000", op_count);
        end
        for (int n = 1; n <= 3; n++) begin
            run_op(M_UP, M_DN, M_P2, 0, 0, "opcnt");
            exp_cnt = 16'(n);
            checks++;
            if (op_count !== exp_cnt) begin
                errors++;
                $display("FAIL opcnt_step: op_count=%h required %h", op_count, exp_cnt);
            end
        end
        dut.op_count_r = 16'hFFFF;
        run_op(M_ID, M_UP, M_UP, 0, 0, "opcnt_wrap");
        checks++;
        if (op_count !== 16'h0000) begin
            errors++;
            $display("FAIL opcnt_wrap: op_count=%h required 0000", op_count);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_identity();
        test_product();
        test_truncation();
        test_stalls();
        test_reset_abort();
`ifdef MAT_CTRL_OPCNT_EN
        test_opcount();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
